// File: rtl/idli_sqi_mem_gen_m_if.sv
// -----------------------------------------------------------------------------
// idli_sqi_mem_gen_m_if
// SQI bus between the core (master) and the SQI SRAM model (slave).
//   i_sqim_sck   : SQI clock from the core
//   i_sqim_cs    : chip select, active low
//   i_sqim_sio   : SQI data, core -> memory
//   o_sqim_sio   : SQI data, memory -> core
//   o_sqim_oe    : high while the memory drives o_sqim_sio
//   o_sqim_mode  : current mode register (debug/LEDs)
//   o_sqim_state : current FSM state (debug)
// Handshake: there is no valid/ready pair on this bus. The core owns sck and
// cs; data is launched by either side on the SCK fall and captured by the
// other side on the SCK rise, and only while cs is low.
// -----------------------------------------------------------------------------
interface idli_sqi_mem_gen_m_if;
   logic       i_sqim_sck;
   logic       i_sqim_cs;
   logic [3:0] i_sqim_sio;
   logic [3:0] o_sqim_sio;
   logic       o_sqim_oe;
   logic [1:0] o_sqim_mode;
   logic [3:0] o_sqim_state;

   modport master (
      output i_sqim_sck, i_sqim_cs, i_sqim_sio,
      input  o_sqim_sio, o_sqim_oe, o_sqim_mode, o_sqim_state
   );

   modport slave (
      input  i_sqim_sck, i_sqim_cs, i_sqim_sio,
      output o_sqim_sio, o_sqim_oe, o_sqim_mode, o_sqim_state
   );
endinterface

// File: rtl/idli_sqi_mem_gen_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_mem_gen_m
// Parametrised SQI SRAM model clocked entirely by the system clock. The SQI
// clock, chip select and data are oversampled; protocol actions happen on the
// gck cycle after a detected SCK edge.
// Ports:
//   i_sqim_gck : system clock, all state on the rising edge
//   i_sqim_rst : asynchronous active-high reset
//   bus        : SQI bus (slave side), see idli_sqi_mem_gen_m_if
// Commands: 0x03 READ, 0x02 WRITE, 0x01 WRMR, 0x05 RDMR, others ignored.
// Mode register: 00 byte (address held), 10 page (low PAGE_W bits wrap),
// 01/11 sequential (wrap at top of memory).
// -----------------------------------------------------------------------------
module idli_sqi_mem_gen_m #(
   parameter int         ADDR_W   = 17,
   parameter int         PAGE_W   = 5,
   parameter int         DUMMY    = 2,
   parameter logic [1:0] MODE_RST = 2'b01
) (
   input  logic               i_sqim_gck,
   input  logic               i_sqim_rst,
   idli_sqi_mem_gen_m_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] A_ONE      = 1;
   localparam logic [PAGE_W-1:0] P_ONE      = 1;
   localparam logic [7:0]        DUMMY_LAST = 8'(DUMMY - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_WRMR, S_RDMR, S_IGNORE
   } state_t;

   state_t            state;
   logic              sck_q, sck_p, cs_q, cs_p;
   logic [3:0]        sio_q;
   logic [7:0]        cnt;       // nibble count in CMD/ADDR, SCK rises in DUMMY
   logic              half;      // first nibble of a data byte already handled
   logic [3:0]        hold;      // high nibble of command or write byte
   logic              is_read;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        sio_o;
   logic              oe_o;
   logic [1:0]        mode;
   logic [7:0]        mem [DEPTH];

   logic              rise, fall, cs_fall, mem_we;
   logic [7:0]        rd_byte;

   assign rise    = sck_q & ~sck_p;
   assign fall    = ~sck_q & sck_p;
   assign cs_fall = cs_p & ~cs_q;

   // A raised cs blocks the write even if an SCK rise lands in the same cycle.
   assign mem_we  = (state == S_WDATA) && rise && half && !cs_q;
   assign rd_byte = (state == S_RDMR) ? {mode, 6'b0} : mem[addr];

   assign bus.o_sqim_sio   = sio_o;
   assign bus.o_sqim_oe    = oe_o;
   assign bus.o_sqim_mode  = mode;
   assign bus.o_sqim_state = state;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0] m);
      case (m)
         2'b00:   next_addr = a;
         2'b10:   next_addr = {a[ADDR_W-1:PAGE_W], a[PAGE_W-1:0] + P_ONE};
         default: next_addr = a + A_ONE;
      endcase
   endfunction

   // Memory contents are deliberately not reset.
   always_ff @(posedge i_sqim_gck) begin
      if (mem_we) mem[addr] <= {hold, sio_q};
   end

   always_ff @(posedge i_sqim_gck or posedge i_sqim_rst) begin
      if (i_sqim_rst) begin
         state   <= S_IDLE;
         sck_q   <= 1'b0;
         sck_p   <= 1'b0;
         cs_q    <= 1'b1;
         cs_p    <= 1'b1;
         sio_q   <= 4'h0;
         cnt     <= 8'd0;
         half    <= 1'b0;
         hold    <= 4'h0;
         is_read <= 1'b0;
         addr    <= '0;
         sio_o   <= 4'h0;
         oe_o    <= 1'b0;
         mode    <= MODE_RST;
      end else begin
         sck_q <= bus.i_sqim_sck;
         sck_p <= sck_q;
         cs_q  <= bus.i_sqim_cs;
         cs_p  <= cs_q;
         sio_q <= bus.i_sqim_sio;

         if (cs_q) begin
            state <= S_IDLE;
            oe_o  <= 1'b0;
            half  <= 1'b0;
            cnt   <= 8'd0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cs_fall) begin
                     state <= S_CMD;
                     cnt   <= 8'd0;
                     half  <= 1'b0;
                  end
               end

               S_CMD: begin
                  if (rise) begin
                     if (cnt == 8'd0) begin
                        hold <= sio_q;
                        cnt  <= 8'd1;
                     end else begin
                        cnt <= 8'd0;
                        case ({hold, sio_q})
                           8'h03: begin is_read <= 1'b1; state <= S_ADDR; end
                           8'h02: begin is_read <= 1'b0; state <= S_ADDR; end
                           8'h01: state <= S_WRMR;
                           8'h05: state <= S_RDMR;
                           default: state <= S_IGNORE;
                        endcase
                     end
                  end
               end

               // Address bits above ADDR_W fall off the top of the shift.
               S_ADDR: begin
                  if (rise) begin
                     addr <= {addr[ADDR_W-5:0], sio_q};
                     if (cnt == 8'd5) begin
                        cnt <= 8'd0;
                        if (!is_read)        state <= S_WDATA;
                        else if (DUMMY == 0) state <= S_RDATA;
                        else                 state <= S_DUMMY;
                     end else begin
                        cnt <= cnt + 8'd1;
                     end
                  end
               end

               S_DUMMY: begin
                  if (rise) begin
                     if (cnt == DUMMY_LAST) begin
                        cnt   <= 8'd0;
                        state <= S_RDATA;
                     end else begin
                        cnt <= cnt + 8'd1;
                     end
                  end
               end

               // The first fall seen here is the one that ends the dummy phase.
               S_RDATA, S_RDMR: begin
                  if (fall) begin
                     oe_o <= 1'b1;
                     if (!half) begin
                        sio_o <= rd_byte[7:4];
                        half  <= 1'b1;
                     end else begin
                        sio_o <= rd_byte[3:0];
                        half  <= 1'b0;
                        if (state == S_RDATA) addr <= next_addr(addr, mode);
                     end
                  end
               end

               S_WDATA: begin
                  if (rise) begin
                     if (!half) begin
                        hold <= sio_q;
                        half <= 1'b1;
                     end else begin
                        half <= 1'b0;
                        addr <= next_addr(addr, mode);
                     end
                  end
               end

               S_WRMR: begin
                  if (rise) begin
                     if (!half) begin
                        hold <= sio_q;
                        half <= 1'b1;
                     end else begin
                        half  <= 1'b0;
                        mode  <= hold[3:2];
                        state <= S_IGNORE;
                     end
                  end
               end

               default: ;  // S_IGNORE: wait for cs to rise
            endcase
         end
      end
   end

endmodule

// File: tb/tb_idli_sqi_mem_gen_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sqi_mem_gen_m
// Directed and randomized bench for the SQI SRAM model. The core side is
// driven with an SCK of 8 gck cycles; the memory output is sampled just
// before each SCK rise, as the core would. A byte-level reference memory and
// mode register give every expected value.
// -----------------------------------------------------------------------------
module tb_idli_sqi_mem_gen_m;
   localparam int ADDR_W = 17;
   localparam int PAGE_W = 5;
   localparam int DUMMY  = 2;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PAGE   = 2 ** PAGE_W;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [7:0]  ref_mem [int];
   logic [1:0]  ref_mode;
   logic [7:0]  exp_q [$];

   idli_sqi_mem_gen_m_if bus ();

   idli_sqi_mem_gen_m #(
      .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .DUMMY(DUMMY), .MODE_RST(2'b01)
   ) dut (
      .i_sqim_gck(clk),
      .i_sqim_rst(rst),
      .bus(bus.slave)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned model_next(input int unsigned a, input logic [1:0] m);
      case (m)
         2'b00:   return a;
         2'b10:   return (a / PAGE) * PAGE + ((a % PAGE) + 1) % PAGE;
         default: return (a + 1) % DEPTH;
      endcase
   endfunction

   // ---------------- drivers ----------------
   // One SCK period: present d, sample memory output before the rise, rise, fall.
   task automatic clk_nib(input logic [3:0] d, output logic [3:0] q, output logic oe);
      bus.i_sqim_sio = d;
      tick(4);
      q  = bus.o_sqim_sio;
      oe = bus.o_sqim_oe;
      bus.i_sqim_sck = 1'b1;
      tick(4);
      bus.i_sqim_sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [3:0] q;
      logic       oe;
      clk_nib(b[7:4], q, oe);
      check("oe_low_in", {31'b0, oe}, 32'd0);
      clk_nib(b[3:0], q, oe);
      check("oe_low_in", {31'b0, oe}, 32'd0);
   endtask

   task automatic recv_check(input string tag);
      logic [3:0] q;
      logic       oe;
      logic [7:0] e;
      e = exp_q.pop_front();
      clk_nib(4'h0, q, oe);
      check({tag, "_oe"}, {31'b0, oe}, 32'd1);
      check({tag, "_hi"}, {28'b0, q}, {28'b0, e[7:4]});
      clk_nib(4'h0, q, oe);
      check({tag, "_oe"}, {31'b0, oe}, 32'd1);
      check({tag, "_lo"}, {28'b0, q}, {28'b0, e[3:0]});
   endtask

   task automatic cs_start();
      bus.i_sqim_cs = 1'b0;
      tick(4);
   endtask

   task automatic cs_end();
      tick(4);
      bus.i_sqim_cs = 1'b1;
      tick(4);
      check("oe_after_cs", {31'b0, bus.o_sqim_oe}, 32'd0);
   endtask

   task automatic send_addr(input logic [23:0] a);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   task automatic mem_write(input int unsigned a, input logic [7:0] data [$]);
      int unsigned ma = a;
      cs_start();
      send_byte(8'h02);
      send_addr(24'(a));
      foreach (data[i]) begin
         send_byte(data[i]);
         ref_mem[ma] = data[i];
         ma = model_next(ma, ref_mode);
      end
      cs_end();
   endtask

   task automatic mem_read(input int unsigned a, input int n, input string tag);
      int unsigned ma = a;
      logic [3:0]  q;
      logic        oe;
      cs_start();
      send_byte(8'h03);
      send_addr(24'(a));
      for (int i = 0; i < DUMMY; i++) begin
         clk_nib(4'h0, q, oe);
         check({tag, "_oe_dummy"}, {31'b0, oe}, 32'd0);
      end
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(ref_mem.exists(ma) ? ref_mem[ma] : 8'hxx);
         ma = model_next(ma, ref_mode);
         recv_check(tag);
      end
      cs_end();
   endtask

   task automatic wrmr(input logic [7:0] v);
      cs_start();
      send_byte(8'h01);
      send_byte(v);
      ref_mode = v[7:6];
      cs_end();
      check("mode_out", {30'b0, bus.o_sqim_mode}, {30'b0, ref_mode});
   endtask

   task automatic rdmr(input int n);
      cs_start();
      send_byte(8'h05);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({ref_mode, 6'b0});
         recv_check("rdmr");
      end
      cs_end();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  d [$];
      logic [3:0]  q;
      logic        oe;
      int unsigned ra;
      int          len;
      logic [1:0]  m;

      rst = 1'b1;
      bus.i_sqim_sck = 1'b0;
      bus.i_sqim_cs  = 1'b1;
      bus.i_sqim_sio = 4'h0;
      ref_mode = 2'b01;
      tick(3);
      check("rst_sio",  {28'b0, bus.o_sqim_sio},  32'd0);
      check("rst_oe",   {31'b0, bus.o_sqim_oe},   32'd0);
      check("rst_mode", {30'b0, bus.o_sqim_mode}, 32'd1);
      rst = 1'b0;
      tick(4);

      // basic write/read
      d = '{8'h5E};        mem_write(32'h101, d);
      d = '{8'hA5, 8'h3C}; mem_write(32'h10, d);
      mem_read(32'h10, 2, "rd_basic");

      // sequential wrap at top of memory
      d = '{8'h11, 8'h22}; mem_write(32'h1FFFF, d);
      mem_read(32'h1FFFF, 1, "rd_wrap_top");
      mem_read(32'h0, 1, "rd_wrap_zero");

      // half byte aborted by cs rise
      d = '{8'h77};        mem_write(32'h200, d);
      cs_start();
      send_byte(8'h02);
      send_addr(24'h000200);
      clk_nib(4'h1, q, oe);
      cs_end();
      mem_read(32'h200, 1, "rd_abort");

      // unknown command never drives
      cs_start();
      send_byte(8'hFF);
      send_byte(8'h00);
      send_byte(8'h00);
      cs_end();
      mem_read(32'h10, 1, "rd_after_ign");

      // page mode
      wrmr(8'h80);
      d = '{8'hAA, 8'hBB}; mem_write(32'h3F, d);
      mem_read(32'h20, 1, "rd_page_wrap");
      mem_read(32'h3F, 1, "rd_page_start");
      rdmr(2);

      // byte mode
      wrmr(8'h00);
      d = '{8'h01, 8'h02, 8'h03}; mem_write(32'h100, d);
      mem_read(32'h100, 2, "rd_byte_mode");
      mem_read(32'h101, 1, "rd_byte_neigh");
      rdmr(1);

      // randomized modes, addresses and bursts
      for (int r = 0; r < 8; r++) begin
         m   = 2'($urandom_range(0, 3));
         wrmr({m, 6'b0});
         ra  = $urandom_range(0, DEPTH - 1);
         len = $urandom_range(1, 4);
         d   = {};
         for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
         mem_write(ra, d);
         mem_read(ra, len, "rd_rand");
      end

      // reset in the middle of a read data phase
      wrmr(8'h80);
      cs_start();
      send_byte(8'h03);
      send_addr(24'h000010);
      for (int i = 0; i < DUMMY; i++) clk_nib(4'h0, q, oe);
      exp_q.push_back(ref_mem[32'h10]);
      recv_check("rd_pre_rst");
      tick(2);
      check("oe_pre_rst", {31'b0, bus.o_sqim_oe}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_oe",  {31'b0, bus.o_sqim_oe},   32'd0);
      check("rst_mid_sio", {28'b0, bus.o_sqim_sio},  32'd0);
      check("rst_mid_mode", {30'b0, bus.o_sqim_mode}, 32'd1);
      tick(1);
      bus.i_sqim_cs = 1'b1;
      tick(3);
      rst = 1'b0;
      ref_mode = 2'b01;
      tick(4);
      mem_read(32'h10, 2, "rd_post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idli_sqi_mem_gen_m.md
Name: idli_sqi_mem_gen_m

Overview:
Parametrised, synthesisable SQI SRAM model for FPGA benches and simulation. It is the successor to the fixed single-size memory model. Depth, address width and read dummy cycles are configurable, and it adds a mode register with byte, page and sequential wrap modes. It is clocked entirely by the system clock and oversamples the SQI clock from the core, so it fits the single-clock FPGA flow. One instance per memory bank (lo/hi) sits beside idli_top_m.

Parameters:
ADDR_W, 17, byte address bits implemented; depth is 2**ADDR_W bytes.
PAGE_W, 5, page size log2 in bytes for page mode (32 B).
DUMMY, 2, dummy SCK cycles between last address nibble and first read nibble.
MODE_RST, 2'b01, mode register reset value (sequential).

Ports:
i_sqim_gck  in  1  system clock; all state on rising edge.
i_sqim_rst  in  1  asynchronous, active-high reset.
i_sqim_sck  in  1  SQI clock from core, max frequency gck/4.
i_sqim_cs  in  1  chip select, active low.
i_sqim_sio  in  4  SQI data from core.
o_sqim_sio  out  4  SQI data to core.
o_sqim_oe  out  1  high while model drives o_sqim_sio (read/RDMR data phase).
o_sqim_mode  out  2  current mode register (debug/LEDs).

Behaviour:
- Reset values: o_sqim_sio=0, o_sqim_oe=0, o_sqim_mode=MODE_RST, FSM=IDLE. Memory contents are not reset.
- Input sampling: sck, cs and sio are registered once into gck.
  - SCK rise = registered sck 1 and previous sample 0; SCK fall is the inverse.
  - All protocol actions occur on the gck cycle after the detected edge.
- Nibbles are shifted MSB first: 2 command nibbles, then 6 address nibbles (24 bits). Address bits above ADDR_W are ignored.
- Commands: 0x03 READ, 0x02 WRITE, 0x01 WRMR, 0x05 RDMR. Any other command goes to IGNORE until cs rises.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, WRMR, RDMR, IGNORE.
  - IDLE->CMD on cs falling.
  - CMD->ADDR (READ/WRITE), ->WRMR, ->RDMR or ->IGNORE after the 2nd nibble.
  - ADDR->DUMMY (READ) or ->WDATA (WRITE) after the 6th nibble.
  - DUMMY->RDATA after DUMMY SCK rises; DUMMY=0 goes straight to RDATA.
  - cs high in any state -> IDLE next cycle, o_sqim_oe=0.
- READ:
  - o_sqim_oe asserts on the SCK fall that ends dummy.
  - High nibble of mem[addr] is presented on that fall and the low nibble on the next fall; the core samples on SCK rise.
  - The address advances after each full byte.
- WRITE: nibbles are assembled on SCK rise. The byte is written to mem[addr] on the 2nd nibble, then the address advances. A half byte at cs rise is discarded with no write.
- Address advance by mode:
  - 00 byte: address held.
  - 10 page: low PAGE_W bits wrap and upper bits are held.
  - 01 sequential: wrap at 2**ADDR_W-1 -> 0.
  - 11 reserved: treated as sequential.
- WRMR: one data byte; bits[7:6] load the mode register at the 2nd nibble. RDMR outputs {mode,6'b0} using READ timing with no address or dummy phase, repeating while clocked.
- Reset mid-transaction: the FSM returns to IDLE immediately, o_sqim_oe drops asynchronously, and a byte in flight is not written.
- A simultaneous cs rise and SCK edge: cs wins and the edge is ignored.

Test Plan:
- WRITE 0x02 at addr 0x000010, data 0xA5,0x3C, then READ 0x03 same addr with 2 dummy -> o_sqim_sio nibbles A,5,3,C; o_sqim_oe high only during data.
- Sequential wrap: write 0x11,0x22 starting at 0x1FFFF (ADDR_W=17) -> read 0x1FFFF gives 0x11, read 0x00000 gives 0x22.
- Page mode: WRMR 0x80, write 0xAA,0xBB at 0x0003F -> 0xBB lands at 0x00020; RDMR returns 0x80; o_sqim_mode=2'b10.
- Byte mode: WRMR 0x00, write 0x01,0x02,0x03 at 0x100 -> read 0x100 gives 0x03, 0x101 is unchanged.
- Aborts:
  - cs raised after the 1st nibble of a write byte -> memory unchanged.
  - Unknown command 0xFF -> o_sqim_oe stays 0 until cs rises, then the next READ works.
- Assert i_sqim_rst during RDATA -> o_sqim_oe=0 and o_sqim_sio=0 the same cycle; o_sqim_mode returns to 2'b01; previously written data still reads back correctly.
